// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Package : cpu_defs
// Purpose : Shared widths, the "no register" address, ALU opcodes and the
//           decoded control bundle. RegisterHeap, the control unit and the
//           ID/EX stage all use these definitions.
// Revision: 1.0  initial release
// ============================================================================
package cpu_defs;

  localparam int DATA_W  = 16;
  localparam int REG_AW  = 4;
  localparam int ALUOP_W = 4;

  // Address that never takes part in forwarding or hazard matching.
  localparam logic [REG_AW-1:0] NOREG = 4'hF;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_PASS = 4'h9
  } alu_op_e;

  // Decoded control carried from decode into EX.
  typedef struct packed {
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
  } ex_ctrl_t;

  // True when a write to wr_addr by a writing stage supplies src.
  function automatic logic reg_match(input logic             we,
                                     input logic [REG_AW-1:0] wr_addr,
                                     input logic [REG_AW-1:0] src);
    return we && (wr_addr == src) && (src != NOREG);
  endfunction

endpackage : cpu_defs
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module  : fwd_mux
// Purpose : Priority compare-and-select for one operand. Source A (the newer
//           result) beats source B; with no match the default value passes.
//           Tie A off (we=0) to get a single-source bypass.
// Ports   : src            register being read
//           a_we/a_addr/a_data   higher-priority result
//           b_we/b_addr/b_data   lower-priority result
//           dflt           value used when neither source matches
//           result         selected operand
// Revision: 1.0  initial release
// ============================================================================
module fwd_mux
  import cpu_defs::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              a_we,
  input  logic [REG_AW-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_we,
  input  logic [REG_AW-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic [DATA_W-1:0] dflt,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = dflt;
    if (reg_match(a_we, a_addr, src)) begin
      result = a_data;
    end else if (reg_match(b_we, b_addr, src)) begin
      result = b_data;
    end
  end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage
// Purpose : Decode-to-execute pipeline register behind RegisterHeap.
//           Captures read data and decoded control, bypasses same-edge
//           write-back into the captured operands, forwards EX/MEM and MEM/WB
//           results onto the EX operands, and raises stall_o on load-use.
// Ports   : CLK, RST (async, active low)
//           decode side : valid_i, rdreg1/2_i, rdata1/2_i, imm_i, wrreg_i,
//                         regwrite_i, memread_i, memwrite_i, alusrc_i, aluop_i
//           core control: hold_i (freeze), flush_i (kill)
//           results     : exmem_* (EX/MEM), memwb_* (MEM/WB)
//           EX side     : valid_o, op1_o, op2_o, imm_o, wrreg_o, regwrite_o,
//                         memread_o, memwrite_o, alusrc_o, aluop_o
//           hazard      : stall_o
// Revision: 1.0  initial release
// ============================================================================
module id_ex_stage
  import cpu_defs::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               valid_i,
  input  logic [REG_AW-1:0]  rdreg1_i,
  input  logic [REG_AW-1:0]  rdreg2_i,
  input  logic [DATA_W-1:0]  rdata1_i,
  input  logic [DATA_W-1:0]  rdata2_i,
  input  logic [DATA_W-1:0]  imm_i,
  input  logic [REG_AW-1:0]  wrreg_i,
  input  logic               regwrite_i,
  input  logic               memread_i,
  input  logic               memwrite_i,
  input  logic               alusrc_i,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic               exmem_regwrite_i,
  input  logic [REG_AW-1:0]  exmem_wrreg_i,
  input  logic [DATA_W-1:0]  exmem_data_i,
  input  logic               memwb_regwrite_i,
  input  logic [REG_AW-1:0]  memwb_wrreg_i,
  input  logic [DATA_W-1:0]  memwb_data_i,
  output logic               valid_o,
  output logic [DATA_W-1:0]  op1_o,
  output logic [DATA_W-1:0]  op2_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic [REG_AW-1:0]  wrreg_o,
  output logic               regwrite_o,
  output logic               memread_o,
  output logic               memwrite_o,
  output logic               alusrc_o,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic               stall_o
);

  // --------------------------------------------------------------------------
  // EX-stage state
  // --------------------------------------------------------------------------
  logic              ex_valid;
  logic [DATA_W-1:0] ex_data [2];   // captured operand values
  logic [REG_AW-1:0] ex_src  [2];   // source addresses, kept for EX forwarding
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_wrreg;
  ex_ctrl_t          ex_ctrl;

  // --------------------------------------------------------------------------
  // Per-operand views of the decode inputs
  // --------------------------------------------------------------------------
  logic [REG_AW-1:0] rd_addr  [2];
  logic [DATA_W-1:0] rd_data  [2];
  logic [DATA_W-1:0] cap_data [2];  // read data after write-back bypass
  logic [DATA_W-1:0] fwd_data [2];  // EX operand after forwarding

  assign rd_addr[0] = rdreg1_i;
  assign rd_addr[1] = rdreg2_i;
  assign rd_data[0] = rdata1_i;
  assign rd_data[1] = rdata2_i;

  genvar g;
  for (g = 0; g < 2; g++) begin : g_opnd
    // RegisterHeap is written on the same edge that this stage captures, so
    // its read port still shows the old value; take the write-back data.
    fwd_mux u_bypass (
      .src    (rd_addr[g]),
      .a_we   (1'b0),
      .a_addr (NOREG),
      .a_data ({DATA_W{1'b0}}),
      .b_we   (memwb_regwrite_i),
      .b_addr (memwb_wrreg_i),
      .b_data (memwb_data_i),
      .dflt   (rd_data[g]),
      .result (cap_data[g])
    );

    // EX/MEM is the younger result and wins over MEM/WB.
    fwd_mux u_fwd (
      .src    (ex_src[g]),
      .a_we   (exmem_regwrite_i),
      .a_addr (exmem_wrreg_i),
      .a_data (exmem_data_i),
      .b_we   (memwb_regwrite_i),
      .b_addr (memwb_wrreg_i),
      .b_data (memwb_data_i),
      .dflt   (ex_data[g]),
      .result (fwd_data[g])
    );
  end

  // --------------------------------------------------------------------------
  // Load-use hazard: the load in EX has no data until MEM, so a dependent
  // instruction in decode must wait one cycle. Suppressed while held, since
  // nothing moves anyway and the bubble would be lost.
  // --------------------------------------------------------------------------
  logic load_use;

  assign load_use = ex_valid && ex_ctrl.memread && (ex_wrreg != NOREG) &&
                    valid_i && ((ex_wrreg == rdreg1_i) || (ex_wrreg == rdreg2_i));
  assign stall_o  = load_use && !hold_i;

  // --------------------------------------------------------------------------
  // Pipeline register. Priority: flush > hold > stall > capture.
  // A bubble clears the source addresses too, so its operand outputs stay 0.
  // --------------------------------------------------------------------------
  logic load_bubble;

  assign load_bubble = flush_i || stall_o;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ex_valid   <= 1'b0;
      ex_data[0] <= '0;
      ex_data[1] <= '0;
      ex_src[0]  <= NOREG;
      ex_src[1]  <= NOREG;
      ex_imm     <= '0;
      ex_wrreg   <= NOREG;
      ex_ctrl    <= '0;
    end else if (load_bubble) begin
      ex_valid   <= 1'b0;
      ex_data[0] <= '0;
      ex_data[1] <= '0;
      ex_src[0]  <= NOREG;
      ex_src[1]  <= NOREG;
      ex_imm     <= '0;
      ex_wrreg   <= NOREG;
      ex_ctrl    <= '0;
    end else if (!hold_i) begin
      ex_valid         <= valid_i;
      ex_data[0]       <= cap_data[0];
      ex_data[1]       <= cap_data[1];
      ex_src[0]        <= rdreg1_i;
      ex_src[1]        <= rdreg2_i;
      ex_imm           <= imm_i;
      ex_wrreg         <= wrreg_i;
      // Side-effecting controls only survive for a real instruction.
      ex_ctrl.regwrite <= regwrite_i && valid_i;
      ex_ctrl.memread  <= memread_i  && valid_i;
      ex_ctrl.memwrite <= memwrite_i && valid_i;
      ex_ctrl.alusrc   <= alusrc_i;
      ex_ctrl.aluop    <= aluop_i;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign valid_o    = ex_valid;
  assign op1_o      = fwd_data[0];
  assign op2_o      = fwd_data[1];
  assign imm_o      = ex_imm;
  assign wrreg_o    = ex_wrreg;
  assign regwrite_o = ex_ctrl.regwrite;
  assign memread_o  = ex_ctrl.memread;
  assign memwrite_o = ex_ctrl.memwrite;
  assign alusrc_o   = ex_ctrl.alusrc;
  assign aluop_o    = ex_ctrl.aluop;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_stage
// Purpose : Self-checking bench for id_ex_stage: directed scenarios plus a
//           randomized run against a behavioural model of the stage.
// Revision: 1.0  initial release
// ============================================================================
module tb_id_ex_stage;
  import cpu_defs::*;

  logic               CLK, RST;
  logic               valid_i;
  logic [REG_AW-1:0]  rdreg1_i, rdreg2_i, wrreg_i;
  logic [DATA_W-1:0]  rdata1_i, rdata2_i, imm_i;
  logic               regwrite_i, memread_i, memwrite_i, alusrc_i;
  logic [ALUOP_W-1:0] aluop_i;
  logic               hold_i, flush_i;
  logic               exmem_regwrite_i, memwb_regwrite_i;
  logic [REG_AW-1:0]  exmem_wrreg_i, memwb_wrreg_i;
  logic [DATA_W-1:0]  exmem_data_i, memwb_data_i;
  logic               valid_o;
  logic [DATA_W-1:0]  op1_o, op2_o, imm_o;
  logic [REG_AW-1:0]  wrreg_o;
  logic               regwrite_o, memread_o, memwrite_o, alusrc_o;
  logic [ALUOP_W-1:0] aluop_o;
  logic               stall_o;

  int total = 0;
  int bad   = 0;

  id_ex_stage dut (
    .CLK(CLK), .RST(RST), .valid_i(valid_i),
    .rdreg1_i(rdreg1_i), .rdreg2_i(rdreg2_i),
    .rdata1_i(rdata1_i), .rdata2_i(rdata2_i), .imm_i(imm_i),
    .wrreg_i(wrreg_i), .regwrite_i(regwrite_i), .memread_i(memread_i),
    .memwrite_i(memwrite_i), .alusrc_i(alusrc_i), .aluop_i(aluop_i),
    .hold_i(hold_i), .flush_i(flush_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_wrreg_i(exmem_wrreg_i),
    .exmem_data_i(exmem_data_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_wrreg_i(memwb_wrreg_i),
    .memwb_data_i(memwb_data_i),
    .valid_o(valid_o), .op1_o(op1_o), .op2_o(op2_o), .imm_o(imm_o),
    .wrreg_o(wrreg_o), .regwrite_o(regwrite_o), .memread_o(memread_o),
    .memwrite_o(memwrite_o), .alusrc_o(alusrc_o), .aluop_o(aluop_o),
    .stall_o(stall_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model: what sits in EX ----------------
  logic               m_valid, m_rw, m_mr, m_mw, m_as;
  logic [DATA_W-1:0]  m_d1, m_d2, m_imm;
  logic [REG_AW-1:0]  m_s1, m_s2, m_wrreg;
  logic [ALUOP_W-1:0] m_aluop;

  // Value a register reads as in decode, given write-back on the same edge.
  function automatic logic [DATA_W-1:0] decode_read(input logic [REG_AW-1:0] r,
                                                    input logic [DATA_W-1:0] heap);
    if (r != NOREG && memwb_regwrite_i && memwb_wrreg_i == r) return memwb_data_i;
    return heap;
  endfunction

  // Newest available value for a register read by the EX instruction.
  function automatic logic [DATA_W-1:0] newest(input logic [REG_AW-1:0] r,
                                               input logic [DATA_W-1:0] held);
    if (r == NOREG) return held;
    if (exmem_regwrite_i && exmem_wrreg_i == r) return exmem_data_i;
    if (memwb_regwrite_i && memwb_wrreg_i == r) return memwb_data_i;
    return held;
  endfunction

  function automatic logic exp_stall();
    if (hold_i || !m_valid || !m_mr || m_wrreg == NOREG || !valid_i) return 1'b0;
    return (m_wrreg == rdreg1_i) || (m_wrreg == rdreg2_i);
  endfunction

  // valid, wrreg, regwrite, memread, memwrite, alusrc, aluop, stall
  function automatic logic [13:0] exp_ctl();
    return {m_valid, m_wrreg, m_rw, m_mr, m_mw, m_as, m_aluop, exp_stall()};
  endfunction

  function automatic logic [3*DATA_W-1:0] exp_dat();
    return {newest(m_s1, m_d1), newest(m_s2, m_d2), m_imm};
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST || flush_i || (!hold_i && exp_stall())) begin
      m_valid <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0; m_as <= 1'b0;
      m_d1 <= '0; m_d2 <= '0; m_imm <= '0; m_aluop <= '0;
      m_s1 <= NOREG; m_s2 <= NOREG; m_wrreg <= NOREG;
    end else if (!hold_i) begin
      m_valid <= valid_i;
      m_rw    <= regwrite_i & valid_i;
      m_mr    <= memread_i & valid_i;
      m_mw    <= memwrite_i & valid_i;
      m_as    <= alusrc_i;
      m_aluop <= aluop_i;
      m_imm   <= imm_i;
      m_wrreg <= wrreg_i;
      m_s1    <= rdreg1_i;
      m_s2    <= rdreg2_i;
      m_d1    <= decode_read(rdreg1_i, rdata1_i);
      m_d2    <= decode_read(rdreg2_i, rdata2_i);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    valid_i = 1'b0; rdreg1_i = 4'h0; rdreg2_i = 4'h0; rdata1_i = '0; rdata2_i = '0;
    imm_i = '0; wrreg_i = NOREG; regwrite_i = 1'b0; memread_i = 1'b0;
    memwrite_i = 1'b0; alusrc_i = 1'b0; aluop_i = '0; hold_i = 1'b0; flush_i = 1'b0;
    exmem_regwrite_i = 1'b0; exmem_wrreg_i = NOREG; exmem_data_i = '0;
    memwb_regwrite_i = 1'b0; memwb_wrreg_i = NOREG; memwb_data_i = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; rdreg1_i = 4'($urandom_range(0, 14)); rdata1_i = 16'($urandom);
      wrreg_i = 4'($urandom_range(0, 14)); regwrite_i = 1'b1; aluop_i = 4'($urandom);
      imm_i = 16'($urandom); memwrite_i = 1'b1; alusrc_i = 1'b1;
      tick();
    end
    RST = 1'b0;
    #1;
    total++;
    if ({valid_o, op1_o, op2_o, imm_o, wrreg_o, regwrite_o, memread_o, memwrite_o,
         alusrc_o, aluop_o, stall_o} !== {1'b0, 48'h0, 4'hF, 4'h0, 4'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_async: got valid=%b op1=%h op2=%h imm=%h wrreg=%h ctl=%b%b%b%b aluop=%h stall=%b, want all 0 with wrreg=f",
               valid_o, op1_o, op2_o, imm_o, wrreg_o, regwrite_o, memread_o,
               memwrite_o, alusrc_o, aluop_o, stall_o);
    end
    tick();
    total++;
    if ({valid_o, op1_o, wrreg_o, regwrite_o, memwrite_o, stall_o} !== {1'b0, 16'h0, 4'hF, 3'b000}) begin
      bad++;
      $display("FAIL reset_held: got valid=%b op1=%h wrreg=%h rw=%b mw=%b stall=%b",
               valid_o, op1_o, wrreg_o, regwrite_o, memwrite_o, stall_o);
    end
    RST = 1'b1;
    valid_i = 1'b1; rdreg1_i = 4'h2; rdata1_i = 16'h7777; wrreg_i = 4'h6;
    regwrite_i = 1'b1; memwrite_i = 1'b0; aluop_i = 4'h3;
    tick();
    idle();
    #1;
    total++;
    if ({valid_o, op1_o, wrreg_o, regwrite_o, aluop_o} !== {1'b1, 16'h7777, 4'h6, 1'b1, 4'h3}) begin
      bad++;
      $display("FAIL reset_first_capture: got valid=%b op1=%h wrreg=%h rw=%b aluop=%h, want 1 7777 6 1 3",
               valid_o, op1_o, wrreg_o, regwrite_o, aluop_o);
    end
  endtask

  task automatic test_capture_bypass();
    idle();
    valid_i = 1'b1; rdreg1_i = 4'h8; rdata1_i = 16'h1234;
    tick();
    total++;
    if (op1_o !== 16'h1234 || valid_o !== 1'b1) begin
      bad++;
      $display("FAIL capture_plain: got op1=%h valid=%b, want 1234 1", op1_o, valid_o);
    end
    memwb_regwrite_i = 1'b1; memwb_wrreg_i = 4'h8; memwb_data_i = 16'hBEEF;
    tick();
    memwb_regwrite_i = 1'b0; memwb_wrreg_i = NOREG; memwb_data_i = '0;
    #1;
    total++;
    if (op1_o !== 16'hBEEF) begin
      bad++;
      $display("FAIL capture_wb_bypass: got op1=%h, want beef", op1_o);
    end
  endtask

  task automatic test_ex_forwarding();
    idle();
    valid_i = 1'b1; rdreg1_i = 4'h3; rdata1_i = 16'h1111;
    tick();
    idle();
    exmem_regwrite_i = 1'b1; exmem_wrreg_i = 4'h3; exmem_data_i = 16'h00AA;
    memwb_regwrite_i = 1'b1; memwb_wrreg_i = 4'h3; memwb_data_i = 16'h0055;
    #1;
    total++;
    if (op1_o !== 16'h00AA) begin
      bad++;
      $display("FAIL fwd_exmem_priority: got op1=%h, want 00aa", op1_o);
    end
    exmem_regwrite_i = 1'b0;
    #1;
    total++;
    if (op1_o !== 16'h0055) begin
      bad++;
      $display("FAIL fwd_memwb: got op1=%h, want 0055", op1_o);
    end
    memwb_regwrite_i = 1'b0;
    #1;
    total++;
    if (op1_o !== 16'h1111) begin
      bad++;
      $display("FAIL fwd_none: got op1=%h, want 1111", op1_o);
    end
  endtask

  task automatic test_load_use();
    idle();
    valid_i = 1'b1; memread_i = 1'b1; regwrite_i = 1'b1; wrreg_i = 4'h5;
    rdreg1_i = 4'h1; rdreg2_i = 4'h2;
    tick();
    idle();
    valid_i = 1'b1; rdreg1_i = 4'h0; rdreg2_i = 4'h5; rdata2_i = 16'h9999;
    wrreg_i = 4'h6; regwrite_i = 1'b1;
    #1;
    total++;
    if (stall_o !== 1'b1) begin
      bad++;
      $display("FAIL load_use_stall: got stall=%b, want 1", stall_o);
    end
    tick();
    total++;
    if ({valid_o, wrreg_o, regwrite_o, memread_o, stall_o} !== {1'b0, 4'hF, 3'b000}) begin
      bad++;
      $display("FAIL load_use_bubble: got valid=%b wrreg=%h rw=%b mr=%b stall=%b, want 0 f 0 0 0",
               valid_o, wrreg_o, regwrite_o, memread_o, stall_o);
    end
    exmem_regwrite_i = 1'b1; exmem_wrreg_i = 4'h5; exmem_data_i = 16'h4242;
    tick();
    total++;
    if ({valid_o, op2_o, stall_o} !== {1'b1, 16'h4242, 1'b0}) begin
      bad++;
      $display("FAIL load_use_forward: got valid=%b op2=%h stall=%b, want 1 4242 0",
               valid_o, op2_o, stall_o);
    end
  endtask

  task automatic test_flush_hold();
    idle();
    valid_i = 1'b1; memread_i = 1'b1; regwrite_i = 1'b1; wrreg_i = 4'h5;
    tick();
    idle();
    valid_i = 1'b1; rdreg1_i = 4'h5; rdata1_i = 16'h3333; regwrite_i = 1'b1;
    wrreg_i = 4'h6; flush_i = 1'b1;
    #1;
    total++;
    if (stall_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_stall_present: got stall=%b, want 1", stall_o);
    end
    tick();
    flush_i = 1'b0;
    #1;
    total++;
    if ({valid_o, wrreg_o, regwrite_o, memread_o, stall_o} !== {1'b0, 4'hF, 3'b000}) begin
      bad++;
      $display("FAIL flush_bubble: got valid=%b wrreg=%h rw=%b mr=%b stall=%b, want 0 f 0 0 0",
               valid_o, wrreg_o, regwrite_o, memread_o, stall_o);
    end
    idle();
    valid_i = 1'b1; memread_i = 1'b1; regwrite_i = 1'b1; wrreg_i = 4'h5;
    rdreg1_i = 4'h1; rdata1_i = 16'h1357; imm_i = 16'h0ABC; alusrc_i = 1'b1; aluop_i = 4'h9;
    tick();
    idle();
    hold_i = 1'b1; valid_i = 1'b1; rdreg1_i = 4'h5; rdata1_i = 16'hFFFF; wrreg_i = 4'h2;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({valid_o, op1_o, imm_o, wrreg_o, regwrite_o, memread_o, memwrite_o,
           alusrc_o, aluop_o, stall_o} !==
          {1'b1, 16'h1357, 16'h0ABC, 4'h5, 4'b1101, 4'h9, 1'b0}) begin
        bad++;
        $display("FAIL hold_cycle%0d: got valid=%b op1=%h imm=%h wrreg=%h ctl=%b%b%b%b aluop=%h stall=%b",
                 i, valid_o, op1_o, imm_o, wrreg_o, regwrite_o, memread_o,
                 memwrite_o, alusrc_o, aluop_o, stall_o);
      end
      tick();
    end
    hold_i = 1'b0;
    #1;
    total++;
    if (stall_o !== 1'b1) begin
      bad++;
      $display("FAIL hold_release_stall: got stall=%b, want 1", stall_o);
    end
    idle();
  endtask

  task automatic test_noreg();
    idle();
    valid_i = 1'b1; rdreg1_i = NOREG; rdreg2_i = NOREG; rdata1_i = 16'h0101;
    rdata2_i = 16'h0202; memread_i = 1'b1; regwrite_i = 1'b1; wrreg_i = NOREG;
    memwb_regwrite_i = 1'b1; memwb_wrreg_i = NOREG; memwb_data_i = 16'hCAFE;
    tick();
    exmem_regwrite_i = 1'b1; exmem_wrreg_i = NOREG; exmem_data_i = 16'hDEAD;
    #1;
    total++;
    if ({op1_o, op2_o, stall_o} !== {16'h0101, 16'h0202, 1'b0}) begin
      bad++;
      $display("FAIL noreg_no_match: got op1=%h op2=%h stall=%b, want 0101 0202 0",
               op1_o, op2_o, stall_o);
    end
    idle();
  endtask

  task automatic test_random();
    logic [REG_AW-1:0] pool [4];
    pool[0] = 4'h3; pool[1] = 4'h5; pool[2] = 4'h8; pool[3] = NOREG;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        RST = 1'b0;
        #1;
        RST = 1'b1;
      end
      valid_i = ($urandom_range(0, 3) != 0);
      rdreg1_i = pool[$urandom_range(0, 3)]; rdreg2_i = pool[$urandom_range(0, 3)];
      rdata1_i = 16'($urandom); rdata2_i = 16'($urandom); imm_i = 16'($urandom);
      wrreg_i = pool[$urandom_range(0, 3)];
      regwrite_i = 1'($urandom); memread_i = 1'($urandom); memwrite_i = 1'($urandom);
      alusrc_i = 1'($urandom); aluop_i = 4'($urandom);
      hold_i = ($urandom_range(0, 7) == 0); flush_i = ($urandom_range(0, 9) == 0);
      exmem_regwrite_i = 1'($urandom); exmem_wrreg_i = pool[$urandom_range(0, 3)];
      exmem_data_i = 16'($urandom);
      memwb_regwrite_i = 1'($urandom); memwb_wrreg_i = pool[$urandom_range(0, 3)];
      memwb_data_i = 16'($urandom);
      #1;
      total++;
      if ({valid_o, wrreg_o, regwrite_o, memread_o, memwrite_o, alusrc_o, aluop_o,
           stall_o} !== exp_ctl()) begin
        bad++;
        $display("FAIL random_ctl[%0d]: got %b, want %b", n,
                 {valid_o, wrreg_o, regwrite_o, memread_o, memwrite_o, alusrc_o,
                  aluop_o, stall_o}, exp_ctl());
      end
      if (m_valid) begin
        total++;
        if ({op1_o, op2_o, imm_o} !== exp_dat()) begin
          bad++;
          $display("FAIL random_data[%0d]: got op1/op2/imm=%h, want %h", n,
                   {op1_o, op2_o, imm_o}, exp_dat());
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    RST = 1'b0;
    #12;
    RST = 1'b1;
    tick();
    test_reset();
    test_capture_bypass();
    test_ex_forwarding();
    test_load_use();
    test_flush_hold();
    test_noreg();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_id_ex_stage
`default_nettype wire
